// File: rtl/bitrev_pkg.sv
// Shared constants and FSM state type for the serial-ASCII bit reverser.
package bitrev_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_ONE  = 8'h31;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FULL
    } state_t;

endpackage

// File: rtl/bit_reverser.sv
// Collects ASCII '0'/'1' characters LSB-first into a WIDTH-bit word and hands
// complete words to a double-buffered output register with valid/ready flow.
module bit_reverser
    import bitrev_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 in_char,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [WIDTH-1:0]           out_word,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       err,
    output logic [$clog2(WIDTH+1)-1:0] bit_count
);

    localparam int CW = $clog2(WIDTH+1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] out_word_reg, out_word_next;
    logic             out_valid_reg, out_valid_next;
    logic             err_reg, err_next;

    logic             accept;
    logic             is_bit;
    logic             out_free;
    logic [WIDTH-1:0] acc_with_bit;

    // in_ready is gated by reset so nothing is accepted while held in reset.
    assign in_ready     = reset && (state_reg != FULL);
    assign accept       = in_valid && in_ready;
    assign is_bit       = (in_char == ASCII_ZERO) || (in_char == ASCII_ONE);
    assign out_free     = !out_valid_reg || out_ready;
    assign acc_with_bit = acc_reg | (WIDTH'(in_char == ASCII_ONE) << count_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            count_reg     <= '0;
            out_word_reg  <= '0;
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            count_reg     <= count_next;
            out_word_reg  <= out_word_next;
            out_valid_reg <= out_valid_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        count_next     = count_reg;
        out_word_next  = out_word_reg;
        out_valid_next = out_valid_reg && !out_ready;
        err_next       = 1'b0;

        // flush only touches the collecting side; the output register keeps draining.
        if (flush) begin
            state_next = IDLE;
            acc_next   = '0;
            count_next = '0;
        end else begin
            case (state_reg)
                IDLE, COLLECT: begin
                    if (accept) begin
                        if (!is_bit) begin
                            err_next = 1'b1;
                        end else if (count_reg == CW'(WIDTH - 1)) begin
                            if (out_free) begin
                                out_word_next  = acc_with_bit;
                                out_valid_next = 1'b1;
                                acc_next       = '0;
                                count_next     = '0;
                                state_next     = IDLE;
                            end else begin
                                acc_next   = acc_with_bit;
                                count_next = CW'(WIDTH);
                                state_next = FULL;
                            end
                        end else begin
                            acc_next   = acc_with_bit;
                            count_next = count_reg + CW'(1);
                            state_next = COLLECT;
                        end
                    end
                end
                FULL: begin
                    if (out_free) begin
                        out_word_next  = acc_reg;
                        out_valid_next = 1'b1;
                        acc_next       = '0;
                        count_next     = '0;
                        state_next     = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign out_word  = out_word_reg;
    assign out_valid = out_valid_reg;
    assign err       = err_reg;
    assign bit_count = count_reg;

endmodule

// File: tb/tb_bit_reverser.sv
// Self-checking bench: directed table, hand-written corner sequences and
// randomized traffic, all compared against a queue-based reference model.
module tb_bit_reverser;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH+1);

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       in_char;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] out_word;
    logic             out_valid;
    logic             out_ready;
    logic             err;
    logic [CW-1:0]    bit_count;

    always #5 clk = ~clk;

    bit_reverser #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_char   (in_char),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .bit_count (bit_count)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: received bits in arrival order plus the word stuck waiting.
    bit               mq[$];
    bit               m_held;
    logic [WIDTH-1:0] m_hw;
    logic [WIDTH-1:0] m_ow;
    bit               m_ov;
    bit               m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_held = 0;
        m_hw   = '0;
        m_ow   = '0;
        m_ov   = 0;
        m_err  = 0;
    endtask

    task automatic model_edge();
        bit               accept;
        bit               free;
        logic [WIDTH-1:0] w;
        if (!reset) begin
            model_clear();
            return;
        end
        accept = in_valid && !m_held;
        free   = !m_ov || out_ready;
        m_err  = 0;
        if (out_ready) m_ov = 0;
        if (flush) begin
            mq.delete();
            m_held = 0;
        end else if (m_held) begin
            if (free) begin
                m_ov   = 1;
                m_ow   = m_hw;
                m_held = 0;
            end
        end else if (accept) begin
            if (in_char == 8'h30 || in_char == 8'h31) begin
                mq.push_back(in_char == 8'h31);
                if (mq.size() == WIDTH) begin
                    w = '0;
                    for (int k = 0; k < WIDTH; k++) w = w + (WIDTH'(mq[k]) * WIDTH'(2**k));
                    mq.delete();
                    if (free) begin
                        m_ov = 1;
                        m_ow = w;
                    end else begin
                        m_held = 1;
                        m_hw   = w;
                    end
                end
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        int exp_cnt;
        exp_cnt = m_held ? WIDTH : mq.size();
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, ".out_word"},  32'(out_word),  32'(m_ow));
        chk({tag, ".err"},       32'(err),       32'(m_err));
        chk({tag, ".bit_count"}, 32'(bit_count), 32'(exp_cnt));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(reset && !m_held));
    endtask

    task automatic step(input logic v, input logic [7:0] ch, input logic ordy, input logic fl,
                        input string tag);
        in_valid  = v;
        in_char   = ch;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] ch;
        logic       ordy;
        logic       fl;
        logic       e_ov;
        logic [7:0] e_ow;
        logic       e_err;
        int         e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [7:0] ch, logic ordy, logic fl,
                                logic e_ov, logic [7:0] e_ow, logic e_err, int e_cnt);
        vec_t r;
        r.v = v; r.ch = ch; r.ordy = ordy; r.fl = fl;
        r.e_ov = e_ov; r.e_ow = e_ow; r.e_err = e_err; r.e_cnt = e_cnt;
        return r;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int pulses;
        int last;
        reset = 1'b0; in_valid = 1'b0; in_char = 8'h30; out_ready = 1'b0; flush = 1'b0;
        model_clear();
        #1;
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.out_word",  32'(out_word),  0);
        chk("rst.bit_count", 32'(bit_count), 0);
        chk("rst.in_ready",  32'(in_ready),  0);
        step(1, 8'h31, 1, 0, "rst_hold");
        reset = 1'b1;
        step(0, 8'h30, 1, 0, "rst_rel");

        // 0x0F word, then invalid-char handling, then a clearing flush.
        tbl.push_back(mk(1, 8'h31, 1, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 8'h31, 1, 0, 0, 8'h00, 0, 2));
        tbl.push_back(mk(1, 8'h31, 1, 0, 0, 8'h00, 0, 3));
        tbl.push_back(mk(1, 8'h31, 1, 0, 0, 8'h00, 0, 4));
        tbl.push_back(mk(1, 8'h30, 1, 0, 0, 8'h00, 0, 5));
        tbl.push_back(mk(1, 8'h30, 1, 0, 0, 8'h00, 0, 6));
        tbl.push_back(mk(1, 8'h30, 1, 0, 0, 8'h00, 0, 7));
        tbl.push_back(mk(1, 8'h30, 1, 0, 1, 8'h0F, 0, 0));
        tbl.push_back(mk(0, 8'h30, 1, 0, 0, 8'h0F, 0, 0));
        tbl.push_back(mk(1, 8'h31, 1, 0, 0, 8'h0F, 0, 1));
        tbl.push_back(mk(1, 8'h41, 1, 0, 0, 8'h0F, 1, 1));
        tbl.push_back(mk(1, 8'h31, 1, 0, 0, 8'h0F, 0, 2));
        tbl.push_back(mk(0, 8'h30, 1, 0, 0, 8'h0F, 0, 2));
        tbl.push_back(mk(0, 8'h30, 1, 1, 0, 8'h0F, 0, 0));
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].ch, tbl[i].ordy, tbl[i].fl, "tbl");
            chk("tbl.out_valid", 32'(out_valid), 32'(tbl[i].e_ov));
            chk("tbl.out_word",  32'(out_word),  32'(tbl[i].e_ow));
            chk("tbl.err",       32'(err),       32'(tbl[i].e_err));
            chk("tbl.bit_count", 32'(bit_count), 32'(tbl[i].e_cnt));
        end

        // Backpressure: 0x01 held, second word parks in FULL, then both drain back-to-back.
        step(1, 8'h31, 0, 0, "bp");
        for (int i = 0; i < 7; i++) step(1, 8'h30, 0, 0, "bp");
        chk("bp.first_word", 32'(out_word), 32'h01);
        for (int i = 0; i < 7; i++) step(1, 8'h30, 0, 0, "bp");
        step(1, 8'h31, 0, 0, "bp");
        chk("bp.full_in_ready", 32'(in_ready), 0);
        chk("bp.full_count", 32'(bit_count), 32'(WIDTH));
        chk("bp.still_01", 32'(out_word), 32'h01);
        step(0, 8'h30, 1, 0, "bp");
        chk("bp.second_word", 32'(out_word), 32'h80);
        chk("bp.no_bubble", 32'(out_valid), 1);
        step(0, 8'h30, 1, 0, "bp");
        chk("bp.drained", 32'(out_valid), 0);

        // flush collides with an accepted character.
        for (int i = 0; i < 5; i++) step(1, 8'h31, 1, 0, "fl");
        step(1, 8'h31, 1, 1, "fl");
        chk("fl.count", 32'(bit_count), 0);
        chk("fl.err", 32'(err), 0);
        step(1, 8'h30, 1, 0, "fl");
        chk("fl.err_next", 32'(err), 0);
        for (int i = 0; i < 6; i++) step(1, 8'h30, 1, 0, "fl");
        step(1, 8'h31, 1, 0, "fl");
        chk("fl.clean_word", 32'(out_word), 32'h80);

        // Async reset mid-word with a word sitting in the output register.
        for (int i = 0; i < 8; i++) step(1, 8'h31, 0, 0, "ar");
        for (int i = 0; i < 6; i++) step(1, 8'h30, 0, 0, "ar");
        chk("ar.pre_valid", 32'(out_valid), 1);
        reset = 1'b0;
        #1;
        chk("ar.out_valid", 32'(out_valid), 0);
        chk("ar.out_word",  32'(out_word),  0);
        chk("ar.bit_count", 32'(bit_count), 0);
        chk("ar.in_ready",  32'(in_ready),  0);
        step(1, 8'h31, 1, 0, "ar");
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step(1, 8'h31, 1, 0, "ar");
        chk("ar.word_ff", 32'(out_word), 32'hFF);

        // Continuous streaming: three words, one every WIDTH cycles.
        pulses = 0;
        last   = -1;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            step(1, 8'h30 + 8'((i * 7 + 3) % 2), 1, 0, "st");
            chk("st.in_ready", 32'(in_ready), 1);
            if (out_valid) begin
                if (last >= 0) chk("st.spacing", 32'(i - last), 32'(WIDTH));
                last = i;
                pulses++;
            end
        end
        chk("st.pulses", 32'(pulses), 3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ch;
            if ($urandom_range(0, 399) == 0) reset = 1'b0;
            ch = ($urandom_range(0, 9) == 0) ? 8'($urandom) : (8'h30 + 8'($urandom_range(0, 1)));
            step(1'($urandom_range(0, 3) != 0), ch, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 29) == 0), "rnd");
            reset = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_reverser.md
BIT_REVERSER -- requirements
Module: bit_reverser

Interface
REQ-001 Parameter: WIDTH, default 8, number of bits per reversed word (2..16).
REQ-002 clk  input  1  rising-edge clock for all registers.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_char  input  8  ASCII bit character from the input stage: 8'h30 means 0, 8'h31 means 1.
REQ-005 in_valid  input  1  in_char is valid this cycle.
REQ-006 in_ready  output  1  block accepts in_char this cycle.
REQ-007 flush  input  1  synchronous discard of the partially collected word.
REQ-008 out_word  output  WIDTH  reversed word.
REQ-009 out_valid  output  1  out_word holds an unconsumed word.
REQ-010 out_ready  input  1  downstream consumes out_word this cycle.
REQ-011 err  output  1  one-cycle pulse for an accepted character other than 8'h30/8'h31.
REQ-012 bit_count  output  $clog2(WIDTH+1)  number of bits currently held in the accumulator.

Function
REQ-013 A character SHALL be accepted in a cycle iff in_valid && in_ready.
REQ-014 The k-th accepted valid bit of a word (k = 0..WIDTH-1, in arrival order) SHALL land in bit k of the accumulator, so the first-received bit becomes out_word[0].
REQ-015 An accepted invalid character SHALL be consumed, SHALL NOT change the accumulator or bit_count, and SHALL assert err in the next cycle for exactly one cycle.
REQ-016 FSM states SHALL be IDLE (bit_count = 0), COLLECT (0 < bit_count < WIDTH) and FULL (bit_count = WIDTH, word not yet transferred).
REQ-017 Transitions: IDLE->COLLECT on the first accepted valid bit; COLLECT->FULL on the WIDTH-th bit when the output register is occupied and not draining; otherwise the transfer happens directly and the FSM goes to IDLE.
REQ-018 The output register SHALL be "free" in a cycle iff !out_valid || out_ready.
REQ-019 When the WIDTH-th bit is accepted and the output register is free, the full word SHALL appear on out_word with out_valid = 1 on the next edge, giving a latency of 1 cycle from the last bit.
REQ-020 In FULL, the word SHALL transfer on the first cycle the output register is free; bit_count SHALL then return to 0.
REQ-021 in_ready SHALL be 0 in FULL and 1 in IDLE and COLLECT.
REQ-022 out_word and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-023 A simultaneous output drain and transfer SHALL load the new word without a bubble, keeping out_valid = 1.
REQ-024 flush SHALL clear the accumulator and bit_count and force IDLE; it SHALL NOT affect the output register.
REQ-025 If flush coincides with an accepted character, flush SHALL win and the character SHALL be discarded; err SHALL NOT pulse.
REQ-026 flush in FULL SHALL discard the held word.

Reset
REQ-027 While reset = 0: out_valid = 0, out_word = 0, err = 0, bit_count = 0, FSM = IDLE, accumulator = 0.
REQ-028 Reset assertion mid-word SHALL discard partial and held words immediately; no word SHALL be emitted after reset release until WIDTH new bits have been accepted.
REQ-029 in_ready SHALL be 0 while reset = 0.

Structure
REQ-030 Package bitrev_pkg SHALL hold ASCII_ZERO = 8'h30, ASCII_ONE = 8'h31, and the FSM state type (IDLE, COLLECT, FULL).
REQ-031 The block SHALL be a single module with no sub-modules; the accumulator and the output register are separate registers (double buffering).

Verification
REQ-032 Chars 31,31,31,31,30,30,30,30 with out_ready = 1 -> one cycle after the 8th char: out_word = 8'h0F, out_valid = 1 for 1 cycle.
REQ-033 Chars 31,30,30,30,30,30,30,30 with out_ready = 0 -> out_word = 8'h01 held; send a second word 30 x7, 31 -> FULL, in_ready = 0; raise out_ready -> 8'h01 then 8'h80 emitted back-to-back.
REQ-034 Chars 31, 41, 31 -> err pulses 1 cycle after 41; bit_count = 2; out_valid = 0.
REQ-035 Accept 5 bits, then flush together with a 31 char -> bit_count = 0, no err; the next 8 bits form a clean word.
REQ-036 Assert reset after 6 bits and while out_valid = 1 -> all outputs 0 immediately; after release, 8 bits 31 -> out_word = 8'hFF.
REQ-037 Continuous in_valid over 3 words with out_ready = 1 -> in_ready never drops; outputs arrive every 8 cycles.
